conv_result_reader: RTL

Reads a finished conv2d result tensor back out of output memory and streams it to the host or next layer over a valid/ready interface. It is the read side of the memory that conv2d writes through output_addr/output_data/output_we/output_en. It is typically started by conv2d's done pulse. It walks the tensor linearly in NCHW order from BASE_ADDR and sustains one word per cycle under continuous ready.

---
 rtl/conv_pkg.sv | 38 +++
 rtl/conv_result_reader_if.sv | 30 +++
 rtl/conv_skid_fifo.sv | 67 ++++++
 rtl/conv_result_reader.sv | 127 ++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv2d result path.
// Holds the tensor-size helper used by both conv2d (OUTPUT_MEM_SIZE) and the
// result reader, the reader FSM encoding, and a ceil-log2 helper used to size
// counters.
package conv_pkg;

   // Reader FSM: idle, streaming, one-cycle done pulse.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } conv_state_t;

   // Depth of the skid FIFO between the memory read port and the stream.
   localparam int unsigned FIFO_DEPTH = 2;

   // Number of elements in an NCHW tensor.
   function automatic int unsigned conv_total(input int unsigned batch,
                                              input int unsigned chans,
                                              input int unsigned height,
                                              input int unsigned width);
      return batch * chans * height * width;
   endfunction

   // Smallest r with 2**r >= value; 0 for value <= 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned     r;
      longint unsigned p;
      r = 0;
      p = 1;
      while (p < longint'(value)) begin
         p = p << 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/conv_result_reader_if.sv
// Bus bundle between the result reader, the output memory read port and the
// downstream stream sink.
//   mem_addr/mem_en  : read request, master -> memory
//   mem_data         : read data one cycle after mem_en, memory -> master
//   m_valid/m_data/m_last : stream beat, master -> sink
//   m_ready          : sink ready, sink -> master
interface conv_result_reader_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 16
);

   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_en;
   logic [DATA_WIDTH-1:0] mem_data;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;

   modport master (
      output mem_addr, mem_en, m_valid, m_data, m_last,
      input  mem_data, m_ready
   );

   modport slave (
      input  mem_addr, mem_en, m_valid, m_data, m_last,
      output mem_data, m_ready
   );

endinterface

// File: rtl/conv_skid_fifo.sv
// Two-entry FIFO that absorbs read data while the stream sink stalls.
// Ports:
//   clk, rst  : clock and asynchronous active-low reset
//   push, din : write din this cycle
//   pop       : remove the head this cycle (only when count != 0)
//   head      : oldest entry (drives the stream data)
//   count     : number of valid entries, 0..2
// Push and pop in the same cycle are legal at any fill level, including full.
module conv_skid_fifo
   import conv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] head,
   output logic [1:0]            count
);

   logic [DATA_WIDTH-1:0] entry0;
   logic [DATA_WIDTH-1:0] entry1;

   assign head = entry0;

   // entry0 is always the head; entry1 only holds data when full.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         entry0 <= '0;
         entry1 <= '0;
         count  <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  entry0 <= din;
               end else begin
                  entry1 <= din;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               entry0 <= entry1;
               count  <= count - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged: the new word lands behind whatever stays.
               if (count == 2'd2) begin
                  entry0 <= entry1;
                  entry1 <= din;
               end else begin
                  entry0 <= din;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Writing into a full FIFO without draining would silently drop a word.
   assert property (@(posedge clk) disable iff (!rst)
                    !(push && !pop && count == 2'(FIFO_DEPTH)));

endmodule

// File: rtl/conv_result_reader.sv
// Drains a finished conv2d result tensor from output memory and streams it,
// in linear NCHW order starting at BASE_ADDR, over a valid/ready interface.
// Ports:
//   clk, rst : clock and asynchronous active-low reset
//   start    : one-cycle pulse, starts a drain when idle
//   busy     : high while the drain is streaming
//   done     : one-cycle pulse after the final beat transfers
//   bus      : memory read port (mem_addr/mem_en/mem_data, 1-cycle read
//              latency) and stream (m_valid/m_ready/m_data/m_last)
// With m_ready held high the stream sustains one beat per cycle.
module conv_result_reader
   import conv_pkg::*;
#(
   parameter int unsigned BATCH_SIZE   = 1,
   parameter int unsigned OUT_CHANNELS = 1,
   parameter int unsigned OUT_HEIGHT   = 4,
   parameter int unsigned OUT_WIDTH    = 4,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned ADDR_WIDTH   = 16,
   parameter int unsigned BASE_ADDR    = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   conv_result_reader_if.master bus
);

   localparam int unsigned      TOTAL     = conv_total(BATCH_SIZE, OUT_CHANNELS,
                                                       OUT_HEIGHT, OUT_WIDTH);
   localparam int unsigned      CNT_W     = clog2(TOTAL + 1);
   localparam logic [CNT_W-1:0] TOTAL_C   = CNT_W'(TOTAL);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(TOTAL - 1);

   if (TOTAL == 0 || (64'(BASE_ADDR) + 64'(TOTAL)) > (64'd1 << ADDR_WIDTH)) begin : g_bad_cfg
      $error("conv_result_reader: empty tensor or tensor exceeds address space");
   end

   conv_state_t           state;
   logic [CNT_W-1:0]      rd_cnt;
   logic [CNT_W-1:0]      beat_cnt;
   logic                  inflight;
   logic                  issue;
   logic                  pop;
   logic [2:0]            occupancy;
   logic [1:0]            fifo_count;
   logic [DATA_WIDTH-1:0] fifo_head;

   conv_skid_fifo #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight),
      .pop   (pop),
      .din   (bus.mem_data),
      .head  (fifo_head),
      .count (fifo_count)
   );

   // Read issue: a word already in flight will land next cycle, so it counts
   // against FIFO space. The beat leaving this cycle frees a slot, which is
   // what lets a continuously ready sink get one word per cycle without
   // ever overfilling the two entries.
   always_comb begin
      pop       = (fifo_count != 2'd0) && bus.m_ready;
      occupancy = {1'b0, fifo_count} + {2'b00, inflight};
      issue     = (state == RUN) && (rd_cnt < TOTAL_C) &&
                  (occupancy < (3'(FIFO_DEPTH) + {2'b00, pop}));
   end

   assign bus.mem_en   = issue;
   assign bus.mem_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(rd_cnt);
   assign bus.m_valid  = (fifo_count != 2'd0);
   assign bus.m_data   = fifo_head;
   assign bus.m_last   = (fifo_count != 2'd0) && (beat_cnt == LAST_BEAT);

   // Control FSM with its counters. busy and done are registered; the drain
   // ends on the transfer of the last beat rather than on the last read, so
   // done never precedes the final beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         rd_cnt   <= '0;
         beat_cnt <= '0;
         inflight <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         inflight <= issue;
         case (state)
            IDLE: begin
               done     <= 1'b0;
               rd_cnt   <= '0;
               beat_cnt <= '0;
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               if (issue) begin
                  rd_cnt <= rd_cnt + CNT_W'(1);
               end
               if (pop) begin
                  if (beat_cnt == LAST_BEAT) begin
                     state <= FIN;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
